// File: rtl/tron_round_ctrl.sv
// Round sequencer for the tron game: scores crashes, freezes play, sweeps the arena
// to black one pixel per clock, runs the start countdown and releases motion.
module tron_round_ctrl #(
  parameter int X_MIN        = 11,
  parameter int X_MAX        = 148,
  parameter int Y_MIN        = 18,
  parameter int Y_MAX        = 107,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int COUNT_CYCLES = 50000000,
  parameter int COUNT_STEPS  = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       p1_crash,
  input  logic       p2_crash,
  input  logic       start,
  output logic       move_en,
  output logic       round_reset,
  output logic       clr_plot,
  output logic [7:0] clr_x,
  output logic [6:0] clr_y,
  output logic [1:0] countdown,
  output logic [1:0] result,
  output logic [3:0] p1_ones,
  output logic [3:0] p1_tens,
  output logic [3:0] p2_ones,
  output logic [3:0] p2_tens
);

  localparam logic [7:0]  X_MIN_C    = 8'(X_MIN);
  localparam logic [7:0]  X_MAX_C    = 8'(X_MAX);
  localparam logic [6:0]  Y_MIN_C    = 7'(Y_MIN);
  localparam logic [6:0]  Y_MAX_C    = 7'(Y_MAX);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] COUNT_LAST = 32'(COUNT_CYCLES - 1);
  localparam logic [1:0]  STEPS_C    = 2'(COUNT_STEPS);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_COUNTDOWN,
    S_PLAY,
    S_HOLD
  } state_t;

  state_t      state_q,       state_d;
  logic [31:0] cnt_q,         cnt_d;
  logic [7:0]  clr_x_q,       clr_x_d;
  logic [6:0]  clr_y_q,       clr_y_d;
  logic        clr_plot_q,    clr_plot_d;
  logic        move_en_q,     move_en_d;
  logic        round_reset_q, round_reset_d;
  logic [1:0]  countdown_q,   countdown_d;
  logic [1:0]  result_q,      result_d;
  logic [7:0]  p1_score_q,    p1_score_d;   // {tens, ones} BCD
  logic [7:0]  p2_score_q,    p2_score_d;

  // BCD +1 that holds at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the same pre-edge values; the reset here is synchronous, so it sits inside the edge.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q       <= S_CLEAR;
      cnt_q         <= '0;
      clr_x_q       <= X_MIN_C;
      clr_y_q       <= Y_MIN_C;
      clr_plot_q    <= 1'b0;
      move_en_q     <= 1'b0;
      round_reset_q <= 1'b1;
      countdown_q   <= 2'd0;
      result_q      <= 2'b00;
      p1_score_q    <= 8'h00;
      p2_score_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clr_x_q       <= clr_x_d;
      clr_y_q       <= clr_y_d;
      clr_plot_q    <= clr_plot_d;
      move_en_q     <= move_en_d;
      round_reset_q <= round_reset_d;
      countdown_q   <= countdown_d;
      result_q      <= result_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
    end
  end

  // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clr_x_d       = clr_x_q;
    clr_y_d       = clr_y_q;
    clr_plot_d    = clr_plot_q;
    move_en_d     = move_en_q;
    round_reset_d = round_reset_q;
    countdown_d   = countdown_q;
    result_d      = result_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;

    unique case (state_q)
      S_CLEAR: begin
        // Only the post-reset entry arrives with plot low; it starts the sweep here.
        if (!clr_plot_q) begin
          clr_plot_d = 1'b1;
        end else if (clr_x_q == X_MAX_C) begin
          clr_x_d = X_MIN_C;
          if (clr_y_q == Y_MAX_C) begin
            clr_y_d     = Y_MIN_C;
            clr_plot_d  = 1'b0;
            state_d     = S_COUNTDOWN;
            countdown_d = STEPS_C;
            cnt_d       = '0;
          end else begin
            clr_y_d = clr_y_q + 7'd1;
          end
        end else begin
          clr_x_d = clr_x_q + 8'd1;
        end
      end

      S_COUNTDOWN: begin
        if (cnt_q == COUNT_LAST) begin
          cnt_d = '0;
          if (countdown_q <= 2'd1) begin
            state_d       = S_PLAY;
            countdown_d   = 2'd0;
            round_reset_d = 1'b0;
            move_en_d     = 1'b1;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_PLAY: begin
        if (start) begin
          state_d       = S_CLEAR;
          clr_plot_d    = 1'b1;
          clr_x_d       = X_MIN_C;
          clr_y_d       = Y_MIN_C;
          round_reset_d = 1'b1;
          move_en_d     = 1'b0;
          cnt_d         = '0;
        end else if (p1_crash || p2_crash) begin
          state_d   = S_HOLD;
          move_en_d = 1'b0;
          cnt_d     = '0;
          if (p1_crash && p2_crash) begin
            result_d = 2'b11;
          end else if (p1_crash) begin
            result_d   = 2'b10;
            p2_score_d = bcd_inc(p2_score_q);
          end else begin
            result_d   = 2'b01;
            p1_score_d = bcd_inc(p1_score_q);
          end
        end
      end

      S_HOLD: begin
        if (start || cnt_q == HOLD_LAST) begin
          state_d       = S_CLEAR;
          clr_plot_d    = 1'b1;
          clr_x_d       = X_MIN_C;
          clr_y_d       = Y_MIN_C;
          round_reset_d = 1'b1;
          move_en_d     = 1'b0;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

  assign move_en     = move_en_q;
  assign round_reset = round_reset_q;
  assign clr_plot    = clr_plot_q;
  assign clr_x       = clr_x_q;
  assign clr_y       = clr_y_q;
  assign countdown   = countdown_q;
  assign result      = result_q;
  assign p1_ones     = p1_score_q[3:0];
  assign p1_tens     = p1_score_q[7:4];
  assign p2_ones     = p2_score_q[3:0];
  assign p2_tens     = p2_score_q[7:4];

endmodule

// File: tb/tb_tron_round_ctrl.sv
// Scoreboard bench for tron_round_ctrl on a 4x3 arena with short hold/countdown timers.
module tb_tron_round_ctrl;

  localparam int XMN = 0, XMX = 3, YMN = 0, YMX = 2;
  localparam int HOLD = 4, CNT = 3, STEPS = 3;

  logic       CLOCK_50;
  logic       resetn, p1_crash, p2_crash, start;
  logic       move_en, round_reset, clr_plot;
  logic [7:0] clr_x;
  logic [6:0] clr_y;
  logic [1:0] countdown, result;
  logic [3:0] p1_ones, p1_tens, p2_ones, p2_tens;

  tron_round_ctrl #(
    .X_MIN(XMN), .X_MAX(XMX), .Y_MIN(YMN), .Y_MAX(YMX),
    .HOLD_CYCLES(HOLD), .COUNT_CYCLES(CNT), .COUNT_STEPS(STEPS)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .p1_crash(p1_crash), .p2_crash(p2_crash), .start(start),
    .move_en(move_en), .round_reset(round_reset), .clr_plot(clr_plot),
    .clr_x(clr_x), .clr_y(clr_y), .countdown(countdown), .result(result),
    .p1_ones(p1_ones), .p1_tens(p1_tens), .p2_ones(p2_ones), .p2_tens(p2_tens)
  );

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
  } pix_t;

  typedef struct {
    int         p1;
    int         p2;
    logic [1:0] res;
  } score_t;

  pix_t       pix_q[$];
  logic [1:0] cd_q[$];
  score_t     score_q[$];

  int tests = 0;
  int fails = 0;
  int exp_p1 = 0;
  int exp_p2 = 0;
  logic [1:0] exp_res = 2'b00;

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 99) ? 99 : v + 1;
  endfunction

  task automatic wait_plot(input string tag);
    for (int i = 0; i < 40 && clr_plot !== 1'b1; i++) tick();
    tests++;
    if (clr_plot !== 1'b1) begin
      fails++;
      $display("FAIL %s wait_plot: clr_plot=%b, required 1 within 40 clocks", tag, clr_plot);
    end
  endtask

  task automatic run_sweep(input string tag);
    pix_t e;
    for (int y = YMN; y <= YMX; y++)
      for (int x = XMN; x <= XMX; x++) begin
        e.x = 8'(x);
        e.y = 7'(y);
        pix_q.push_back(e);
      end
    wait_plot(tag);
    while (pix_q.size() > 0) begin
      e = pix_q.pop_front();
      tests++;
      if (clr_plot !== 1'b1 || clr_x !== e.x || clr_y !== e.y || round_reset !== 1'b1 || move_en !== 1'b0) begin
        fails++;
        $display("FAIL %s sweep: got plot=%b (%0d,%0d) rr=%b mv=%b, required plot=1 (%0d,%0d) rr=1 mv=0",
                 tag, clr_plot, clr_x, clr_y, round_reset, move_en, e.x, e.y);
      end
      tick();
    end
    tests++;
    if (clr_plot !== 1'b0 || countdown !== 2'(STEPS)) begin
      fails++;
      $display("FAIL %s sweep_end: got plot=%b countdown=%0d, required plot=0 countdown=%0d",
               tag, clr_plot, countdown, STEPS);
    end
  endtask

  task automatic run_countdown(input string tag, input logic poke_start, input logic hold_crash);
    logic [1:0] e;
    for (int s = STEPS; s >= 1; s--)
      for (int c = 0; c < CNT; c++) cd_q.push_back(2'(s));
    while (cd_q.size() > 0) begin
      e = cd_q.pop_front();
      start    = poke_start;
      p1_crash = hold_crash;
      tests++;
      if (countdown !== e || move_en !== 1'b0 || round_reset !== 1'b1 || clr_plot !== 1'b0 ||
          p1_ones !== 4'(exp_p1 % 10) || p2_ones !== 4'(exp_p2 % 10) || result !== exp_res) begin
        fails++;
        $display("FAIL %s countdown: got cd=%0d mv=%b rr=%b plot=%b p1o=%0d p2o=%0d res=%b, required cd=%0d mv=0 rr=1 plot=0 p1o=%0d p2o=%0d res=%b",
                 tag, countdown, move_en, round_reset, clr_plot, p1_ones, p2_ones, result,
                 e, exp_p1 % 10, exp_p2 % 10, exp_res);
      end
      tick();
    end
    start = 1'b0;
    tests++;
    if (move_en !== 1'b1 || round_reset !== 1'b0 || countdown !== 2'd0) begin
      fails++;
      $display("FAIL %s play_entry: got mv=%b rr=%b cd=%0d, required mv=1 rr=0 cd=0",
               tag, move_en, round_reset, countdown);
    end
  endtask

  // Drive one PLAY-clock of crash/start and score the result one clock later.
  task automatic crash_step(input logic c1, input logic c2, input logic s, input string tag);
    score_t e;
    if (!s) begin
      if (c1 && c2) exp_res = 2'b11;
      else if (c1) begin exp_p2 = sat_inc(exp_p2); exp_res = 2'b10; end
      else if (c2) begin exp_p1 = sat_inc(exp_p1); exp_res = 2'b01; end
    end
    e.p1 = exp_p1; e.p2 = exp_p2; e.res = exp_res;
    score_q.push_back(e);
    p1_crash = c1; p2_crash = c2; start = s;
    tick();
    p1_crash = 1'b0; p2_crash = 1'b0; start = 1'b0;
    e = score_q.pop_front();
    tests++;
    if (p1_tens !== 4'(e.p1 / 10) || p1_ones !== 4'(e.p1 % 10) ||
        p2_tens !== 4'(e.p2 / 10) || p2_ones !== 4'(e.p2 % 10) || result !== e.res ||
        move_en !== 1'b0 || round_reset !== s) begin
      fails++;
      $display("FAIL %s score: got p1=%0d%0d p2=%0d%0d res=%b mv=%b rr=%b, required p1=%0d p2=%0d res=%b mv=0 rr=%b",
               tag, p1_tens, p1_ones, p2_tens, p2_ones, result, move_en, round_reset,
               e.p1, e.p2, e.res, s);
    end
  endtask

  task automatic finish_round(input string tag, input logic check_hold,
                              input logic poke_start, input logic hold_crash);
    int n = 0;
    while (clr_plot !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
    if (check_hold) begin
      tests++;
      if (n != HOLD) begin
        fails++;
        $display("FAIL %s hold_len: got %0d clocks, required %0d", tag, n, HOLD);
      end
    end
    run_sweep(tag);
    run_countdown(tag, poke_start, hold_crash);
  endtask

  task automatic check_reset_values(input string tag);
    tests++;
    if (clr_plot !== 1'b0 || clr_x !== 8'(XMN) || clr_y !== 7'(YMN) || move_en !== 1'b0 ||
        round_reset !== 1'b1 || countdown !== 2'd0 || result !== 2'b00 ||
        p1_ones !== 4'd0 || p1_tens !== 4'd0 || p2_ones !== 4'd0 || p2_tens !== 4'd0) begin
      fails++;
      $display("FAIL %s reset_vals: got plot=%b (%0d,%0d) mv=%b rr=%b cd=%0d res=%b p1=%0d%0d p2=%0d%0d, required all idle with rr=1",
               tag, clr_plot, clr_x, clr_y, move_en, round_reset, countdown, result,
               p1_tens, p1_ones, p2_tens, p2_ones);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    resetn = 1'b1;
  endtask

  task automatic test_sweep_countdown();
    run_sweep("first_sweep");
    run_countdown("first_cd", 1'b0, 1'b0);
  endtask

  task automatic test_p1_crash();
    crash_step(1'b1, 1'b0, 1'b0, "p1_crash");
    finish_round("p1_round", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_draw();
    crash_step(1'b1, 1'b1, 1'b0, "draw");
    finish_round("draw_round", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_start();
    crash_step(1'b0, 1'b1, 1'b1, "start_vs_p2");
    finish_round("start_round", 1'b0, 1'b1, 1'b0);
    crash_step(1'b0, 1'b1, 1'b0, "pre_hold_start");
    crash_step(1'b0, 1'b0, 1'b1, "start_in_hold");
    finish_round("hold_start_round", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_level_crash();
    crash_step(1'b0, 1'b1, 1'b0, "level_pre");
    finish_round("level_round", 1'b1, 1'b0, 1'b1);
    crash_step(1'b1, 1'b0, 1'b0, "level_first_play");
    finish_round("level_after", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 100; i++) begin
      crash_step(1'b0, 1'b1, 1'b0, $sformatf("sat%0d", i));
      finish_round("sat_round", 1'b0, 1'b0, 1'b0);
    end
    tests++;
    if (p1_tens !== 4'd9 || p1_ones !== 4'd9) begin
      fails++;
      $display("FAIL saturate: got p1=%0d%0d, required 99", p1_tens, p1_ones);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    crash_step(1'b0, 1'b0, 1'b1, "mid_start");
    while (!(clr_plot === 1'b1 && clr_x === 8'd2 && clr_y === 7'd1) && n < 40) begin
      n++;
      tick();
    end
    tests++;
    if (clr_plot !== 1'b1 || clr_x !== 8'd2 || clr_y !== 7'd1) begin
      fails++;
      $display("FAIL mid_pixel: got plot=%b (%0d,%0d), required plot=1 (2,1)", clr_plot, clr_x, clr_y);
    end
    resetn = 1'b0;
    tick();
    check_reset_values("mid_sweep");
    resetn = 1'b1;
    exp_p1 = 0; exp_p2 = 0; exp_res = 2'b00;
    run_sweep("after_mid_sweep");
    tick();
    tick();
    resetn = 1'b0;
    tick();
    check_reset_values("mid_cd");
    resetn = 1'b1;
    run_sweep("after_mid_cd");
    run_countdown("after_mid_cd", 1'b0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; p1_crash = 1'b0; p2_crash = 1'b0; start = 1'b0;
    test_reset();
    test_sweep_countdown();
    test_p1_crash();
    test_draw();
    test_start();
    test_level_crash();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
